cache_port_arbiter: RTL and testbench

- Shares the single-ported cache controller between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Latches the winner's command, drives the controller's Strobe/RW/address/data, waits for its Rdy pulse, then returns read data and a one-cycle ack to the winner.
- Sits between the CPU-side ports and the cache controller FSM. Fairness is round-robin.

---
 rtl/cache_arb_pkg.sv | 23 ++
 rtl/cache_port_arbiter_rr_pick2.sv | 23 ++
 rtl/cache_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache port arbiter.
//   arb_state_t     : arbiter FSM states
//   port_idx_t      : requester index (0 = instruction fetch, 1 = data)
//   TIMEOUT_DEFAULT : default c_rdy wait limit for the optional timeout
//   to_cnt_w()      : width of the WAIT-state timeout counter for a given limit
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef logic port_idx_t;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

    function automatic int unsigned to_cnt_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector.
//   req[1:0] : pending requests
//   rr_ptr   : port that wins when both are requesting
//   valid    : at least one request pending
//   winner   : selected port (meaningful only while valid is high)
module rr_pick2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  rr_ptr,
    output logic       valid,
    output port_idx_t  winner
);

    always_comb begin
        valid  = |req;
        winner = port_idx_t'(req[1]);
        if (req == 2'b11) begin
            winner = rr_ptr;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single-ported cache controller between an instruction-fetch
// port (0) and a data port (1) with round-robin fairness.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req/rw/addr/wdata 0|1 : requester commands, req held until ack
//   ack0, ack1            : one-cycle completion pulse to the winner
//   rdata                 : read data, valid while ack0/ack1 is high
//   c_strobe/c_rw/c_addr/c_wdata : command to the cache controller
//   c_rdy, c_rdata        : completion and read data from the controller
// Optional build macro CACHE_ARB_TIMEOUT_EN adds err0/err1 and aborts a
// transaction after TIMEOUT WAIT cycles without c_rdy (rdata forced to 0).
// All outputs are registered.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              c_strobe,
    output logic              c_rw,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic              c_rdy,
`ifdef CACHE_ARB_TIMEOUT_EN
    output logic              err0,
    output logic              err1,
`endif
    input  logic [DATA_W-1:0] c_rdata
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cache_port_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_t        state_q, state_d;
    port_idx_t         gnt_q, gnt_d;
    port_idx_t         rr_ptr_q, rr_ptr_d;
    logic              strobe_d, rw_d, ack0_d, ack1_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;

    logic              pick_valid;
    port_idx_t         pick_idx;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int unsigned       CNT_W    = to_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err0_d, err1_d;
`endif

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // Next-state and next-output logic; every output is the registered
    // copy of its *_d value, so pulses are set on the transition into
    // the state in which they must be visible.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        strobe_d = 1'b0;
        rw_d     = c_rw;
        addr_d   = c_addr;
        wdata_d  = c_wdata;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata_d  = rdata;
`ifdef CACHE_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d    = pick_idx;
                    rw_d     = pick_idx ? rw1    : rw0;
                    addr_d   = pick_idx ? addr1  : addr0;
                    wdata_d  = pick_idx ? wdata1 : wdata0;
                    strobe_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef CACHE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (c_rdy) begin
                    rdata_d = c_rdata;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = DONE;
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    err0_d  = ~gnt_q;
                    err1_d  = gnt_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                rr_ptr_d = ~gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            rr_ptr_q <= 1'b0;
            c_strobe <= 1'b0;
            c_rw     <= 1'b0;
            c_addr   <= '0;
            c_wdata  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            c_strobe <= strobe_d;
            c_rw     <= rw_d;
            c_addr   <= addr_d;
            c_wdata  <= wdata_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            rdata    <= rdata_d;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err0     <= err0_d;
            err1     <= err1_d;
`endif
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed table of request
// scenarios, hand-written reset/timeout sequences, and randomized rounds
// checked against a transaction-level round-robin model.
module tb_cache_port_arbiter;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 64;
`endif

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    typedef struct {
        int unsigned n0;
        int unsigned n1;
        int unsigned exp_n;
        logic [15:0] exp_order;
    } vec_t;

    logic        clk, rst_n;
    logic        req0, req1, rw0, rw1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1;
    logic [7:0]  rdata;
    logic        c_strobe, c_rw;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    logic        c_rdy;
    logic [7:0]  c_rdata;
`ifdef CACHE_ARB_TIMEOUT_EN
    logic        err0, err1;
`endif

    int unsigned checks, errors;
    int unsigned resp_delay;
    logic        spur_rdy;
    logic        m_ptr;
    cmd_t        cq0[$];
    cmd_t        cq1[$];

    cache_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .rw0      (rw0),
        .rw1      (rw1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .c_strobe (c_strobe),
        .c_rw     (c_rw),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_rdy    (c_rdy),
`ifdef CACHE_ARB_TIMEOUT_EN
        .err0     (err0),
        .err1     (err1),
`endif
        .c_rdata  (c_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic logic [7:0] ref_rdata(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hE5;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.rw    = 1'($urandom_range(0, 1));
        c.addr  = 16'($urandom);
        c.wdata = 8'($urandom);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache controller model: answers each strobe after resp_delay cycles
    // (0 = never answers); optionally also raises a bogus c_rdy during ISSUE.
    initial begin
        int unsigned d;
        logic [7:0]  data;
        c_rdy   = 1'b0;
        c_rdata = '0;
        forever begin
            @(negedge clk);
            if (c_strobe && rst_n && resp_delay != 0) begin
                d    = resp_delay;
                data = ref_rdata(c_addr);
                if (spur_rdy) begin
                    c_rdy   = 1'b1;
                    c_rdata = 8'hFF;
                end
                for (int i = 0; i < int'(d); i++) begin
                    @(negedge clk);
                    c_rdy = 1'b0;
                end
                c_rdy   = 1'b1;
                c_rdata = data;
                @(negedge clk);
                c_rdy = 1'b0;
            end
        end
    end

    task automatic drive_port(input logic p, input cmd_t c);
        if (p) begin
            req1 = 1'b1; rw1 = c.rw; addr1 = c.addr; wdata1 = c.wdata;
        end else begin
            req0 = 1'b1; rw0 = c.rw; addr0 = c.addr; wdata0 = c.wdata;
        end
    endtask

    // After the latch the port inputs are free to change; sometimes drop req early.
    task automatic scramble(input logic p);
        cmd_t c;
        c = rand_cmd();
        if (p) begin
            rw1 = c.rw; addr1 = c.addr; wdata1 = c.wdata;
            if ($urandom_range(0, 3) == 0) req1 = 1'b0;
        end else begin
            rw0 = c.rw; addr0 = c.addr; wdata0 = c.wdata;
            if ($urandom_range(0, 3) == 0) req0 = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        #1;
        chk("reset_cmd", {c_strobe, c_rw, c_addr, c_wdata}, '0);
        chk("reset_ack", {ack0, ack1, rdata}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 1'b0;
    endtask

    task automatic fill(input int unsigned n0, input int unsigned n1);
        cq0.delete();
        cq1.delete();
        for (int unsigned j = 0; j < n0; j++) cq0.push_back(rand_cmd());
        for (int unsigned j = 0; j < n1; j++) cq1.push_back(rand_cmd());
    endtask

    // Runs every command in cq0/cq1. Each port holds req until its ack,
    // drops it in the ack cycle and re-raises its next command one cycle
    // later. Model: when both ports are pending the winner is m_ptr,
    // otherwise the lone pending port; after a grant m_ptr = other port.
    task automatic serve(output logic [15:0] order, output int unsigned n_ack,
                         output int unsigned n_strobe, output logic [7:0] last_rd);
        int unsigned rem0, rem1, cyc, lat, extra;
        logic [1:0]  raise_pend;
        logic        active, prev_strobe, exp_p;
        cmd_t        cur;
        rem0 = cq0.size(); rem1 = cq1.size();
        order = '0; n_ack = 0; n_strobe = 0; last_rd = '0;
        active = 1'b0; prev_strobe = 1'b0; raise_pend = '0;
        cyc = 0; lat = 0; exp_p = 1'b0; cur = '0; extra = 0;
        @(negedge clk);
        if (rem0 != 0) drive_port(1'b0, cq0[0]);
        if (rem1 != 0) drive_port(1'b1, cq1[0]);
        while ((rem0 + rem1) != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (raise_pend[0]) drive_port(1'b0, cq0[0]);
            if (raise_pend[1]) drive_port(1'b1, cq1[0]);
            raise_pend = '0;
            if (active && !c_strobe) lat++;
            if (c_strobe) begin
                n_strobe++;
                chk("strobe_single", {30'd0, prev_strobe, active}, 0);
                exp_p = (rem0 != 0 && rem1 != 0) ? m_ptr : (rem1 != 0);
                cur   = exp_p ? cq1[0] : cq0[0];
                chk("strobe_cmd", {c_rw, c_addr, c_wdata}, cur);
                active = 1'b1;
                lat    = 0;
                scramble(exp_p);
            end
            if (ack0 || ack1) begin
                if (!active) begin
                    chk("unexpected_ack", {30'd0, ack1, ack0}, 0);
                end else begin
                    chk("ack_port", {30'd0, ack1, ack0}, exp_p ? 32'd2 : 32'd1);
                    chk("ack_rdata", rdata, ref_rdata(cur.addr));
                    chk("cmd_hold", {c_rw, c_addr, c_wdata}, cur);
                    chk("ack_latency", lat, resp_delay + 1);
`ifdef CACHE_ARB_TIMEOUT_EN
                    chk("err_quiet", {err1, err0}, 0);
`endif
                    if (n_ack < 16) order[n_ack] = ack1;
                    n_ack++;
                    last_rd = rdata;
                    if (exp_p) begin
                        void'(cq1.pop_front());
                        rem1--;
                        req1 = 1'b0;
                        raise_pend[1] = (rem1 != 0);
                    end else begin
                        void'(cq0.pop_front());
                        rem0--;
                        req0 = 1'b0;
                        raise_pend[0] = (rem0 != 0);
                    end
                    m_ptr  = ~exp_p;
                    active = 1'b0;
                end
            end
            prev_strobe = c_strobe;
        end
        if ((rem0 + rem1) != 0) chk("serve_budget", rem0 + rem1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (c_strobe || ack0 || ack1) extra++;
        end
        chk("idle_tail", extra, 0);
    endtask

    task automatic wait_strobe(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (c_strobe) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        vec_t        vt[6];
        logic [15:0] order;
        int unsigned n_ack, n_strobe, lat, quiet;
        logic [7:0]  last_rd;
        logic        seen;

        vt[0] = '{n0: 1, n1: 0, exp_n: 1, exp_order: 16'b0};
        vt[1] = '{n0: 1, n1: 1, exp_n: 2, exp_order: 16'b10};
        vt[2] = '{n0: 2, n1: 2, exp_n: 4, exp_order: 16'b1010};
        vt[3] = '{n0: 0, n1: 3, exp_n: 3, exp_order: 16'b111};
        vt[4] = '{n0: 3, n1: 1, exp_n: 4, exp_order: 16'b0010};
        vt[5] = '{n0: 1, n1: 3, exp_n: 4, exp_order: 16'b1110};

        checks = 0; errors = 0;
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        resp_delay = 2; spur_rdy = 1'b0; m_ptr = 1'b0;

        do_reset();

        // Single read from port 0, controller answers 3 cycles after strobe.
        cq0.delete(); cq1.delete();
        cq0.push_back('{rw: 1'b0, addr: 16'h0040, wdata: 8'h00});
        resp_delay = 3;
        serve(order, n_ack, n_strobe, last_rd);
        chk("t1_rdata", last_rd, 8'hA5);
        chk("t1_strobes", n_strobe, 1);
        chk("t1_order", {16'd0, order}, 0);

        // Directed scenarios, each from reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            fill(vt[i].n0, vt[i].n1);
            if (i == 1) begin
                cq0[0].rw = 1'b1; cq0[0].wdata = 8'h11;
                cq1[0].rw = 1'b1; cq1[0].wdata = 8'h22;
            end
            resp_delay = 1 + (i % 3);
            serve(order, n_ack, n_strobe, last_rd);
            chk($sformatf("vec%0d_acks", i), n_ack, vt[i].exp_n);
            chk($sformatf("vec%0d_strobes", i), n_strobe, vt[i].exp_n);
            chk($sformatf("vec%0d_order", i), {16'd0, order}, {16'd0, vt[i].exp_order});
        end

        // Reset in WAIT abandons the transaction and restores port-0 priority.
        fill(1, 0);
        resp_delay = 2;
        serve(order, n_ack, n_strobe, last_rd);
        resp_delay = 0;
        @(negedge clk);
        drive_port(1'b0, '{rw: 1'b1, addr: 16'hBEEF, wdata: 8'h5C});
        wait_strobe(seen);
        chk("rst_strobe_seen", {31'd0, seen}, 1);
        repeat (2) @(negedge clk);
        do_reset();
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1 || c_strobe) quiet++;
        end
        chk("rst_no_ack", quiet, 0);
        resp_delay = 2;
        fill(1, 1);
        serve(order, n_ack, n_strobe, last_rd);
        chk("rst_order", {16'd0, order}, 32'b10);

`ifdef CACHE_ARB_TIMEOUT_EN
        // Controller never answers: abort after TIMEOUT WAIT cycles.
        resp_delay = 0;
        @(negedge clk);
        drive_port(1'b0, '{rw: 1'b0, addr: 16'h1234, wdata: 8'h00});
        wait_strobe(seen);
        chk("to_strobe_seen", {31'd0, seen}, 1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                lat = i;
                break;
            end
        end
        chk("to_latency", lat, TB_TIMEOUT + 1);
        chk("to_flags", {28'd0, ack1, err1, ack0, err0}, 32'b0011);
        chk("to_rdata", rdata, 0);
        req0  = 1'b0;
        m_ptr = 1'b1;
        resp_delay = 2;
        fill(1, 0);
        serve(order, n_ack, n_strobe, last_rd);
        chk("to_recover", n_ack, 1);
`endif

        // Randomized rounds against the round-robin model.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            int unsigned n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            resp_delay = $urandom_range(1, 4);
            spur_rdy   = 1'($urandom_range(0, 1));
            fill(n0, n1);
            serve(order, n_ack, n_strobe, last_rd);
            chk("rand_acks", n_ack, n0 + n1);
        end
        spur_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
